// File: rtl/motion_pkg.sv
// Shared constants and scheduler state encoding for the motion-detect pipeline.
package motion_pkg;

  localparam int PIX_W     = 20;
  localparam int PIPE_LAT  = 4;
  localparam int OUT_DEPTH = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth 1-bit shift register that tracks valids through the datapath.
module valid_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stage_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      stage_reg <= '0;
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/motion_frame_sched.sv
// Per-frame sequencer: lockstep pops of the three input FIFOs, delayed output
// write enable, and credit-based protection of the highlight output FIFO.
module motion_frame_sched #(
  parameter int PIX_W     = motion_pkg::PIX_W,
  parameter int PIPE_LAT  = motion_pkg::PIPE_LAT,
  parameter int OUT_DEPTH = motion_pkg::OUT_DEPTH,
  localparam int CRED_W   = $clog2(OUT_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PIX_W-1:0]  frame_pixels,
  input  logic              bg_empty,
  input  logic              fr_empty,
  input  logic              hl_empty,
  output logic              bg_rd_en,
  output logic              fr_rd_en,
  output logic              hl_rd_en,
  output logic              pipe_valid,
  output logic              out_wr_en,
  input  logic              out_rd_en,
  output logic              busy,
  output logic              frame_done,
  output logic [CRED_W-1:0] credits
);

  import motion_pkg::*;

  sched_state_t      state_reg, state_next;
  logic [PIX_W-1:0]  frame_len_reg;
  logic [PIX_W-1:0]  issued_cnt_reg;
  logic [PIX_W-1:0]  written_cnt_reg;
  logic [CRED_W-1:0] credits_reg, credits_next;
  logic              issue;
  logic              start_ok;
  logic              last_issue;
  logic              last_write;

  assign start_ok = (state_reg == S_IDLE) && start;

  // A single issue pops all three FIFOs; any empty input stalls them together.
  assign issue = (state_reg == S_RUN) && !bg_empty && !fr_empty && !hl_empty
                 && (credits_reg != '0) && (issued_cnt_reg != frame_len_reg);

  assign last_issue = issue && ((issued_cnt_reg + PIX_W'(1)) == frame_len_reg);
  assign last_write = (state_reg == S_DRAIN) && out_wr_en
                      && ((written_cnt_reg + PIX_W'(1)) == frame_len_reg);

  valid_delay_line #(
    .DEPTH (PIPE_LAT)
  ) u_valid_delay (
    .clk   (clk),
    .clear (reset),
    .din   (issue),
    .dout  (out_wr_en)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = (frame_pixels == '0) ? S_DONE : S_RUN;
      S_RUN:   if (last_issue) state_next = S_DRAIN;
      S_DRAIN: if (last_write) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // A consumer pop with every slot already free cannot return a credit.
  always_comb begin
    credits_next = credits_reg;
    if (issue && !out_rd_en) begin
      credits_next = credits_reg - CRED_W'(1);
    end else if (!issue && out_rd_en && (credits_reg != CRED_W'(OUT_DEPTH))) begin
      credits_next = credits_reg + CRED_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      frame_len_reg   <= '0;
      issued_cnt_reg  <= '0;
      written_cnt_reg <= '0;
      credits_reg     <= CRED_W'(OUT_DEPTH);
    end else begin
      state_reg   <= state_next;
      credits_reg <= credits_next;
      if (start_ok) begin
        frame_len_reg   <= frame_pixels;
        issued_cnt_reg  <= '0;
        written_cnt_reg <= '0;
      end else begin
        if (issue)     issued_cnt_reg  <= issued_cnt_reg + PIX_W'(1);
        if (out_wr_en) written_cnt_reg <= written_cnt_reg + PIX_W'(1);
      end
    end
  end

  credit_overflow: assert property (@(posedge clk) disable iff (reset)
    !(out_rd_en && !issue && (credits_reg == CRED_W'(OUT_DEPTH))));

  assign bg_rd_en   = issue;
  assign fr_rd_en   = issue;
  assign hl_rd_en   = issue;
  assign pipe_valid = issue;
  assign busy       = (state_reg == S_RUN) || (state_reg == S_DRAIN);
  assign frame_done = (state_reg == S_DONE);
  assign credits    = credits_reg;

endmodule

// File: doc/motion_frame_sched.md
Name: motion_frame_sched

Overview:
- Per-frame sequencer for the motion-detect pipeline.
- Pops the background, frame and highlight-frame FIFOs in lockstep, one 32-bit pixel word per issue, and issues a valid into the fixed-latency subtract/highlight datapath.
- Generates the highlight output FIFO write enable after the pipeline latency.
- Uses a credit counter so the output FIFO never overflows, and signals frame completion.

Parameters:
PIX_W, 20, width of the pixel counters; max frame = 2^PIX_W-1 words
PIPE_LAT, 4, cycles from issue to the datapath result at the output FIFO input; must be >=1
OUT_DEPTH, 32, depth of the highlight output FIFO, in words

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
frame_pixels  in  PIX_W  number of words in the frame; latched on an accepted start
bg_empty  in  1  background FIFO empty
fr_empty  in  1  frame FIFO empty (subtract path)
hl_empty  in  1  highlight-frame FIFO empty
bg_rd_en  out  1  pop background FIFO
fr_rd_en  out  1  pop frame FIFO
hl_rd_en  out  1  pop highlight-frame FIFO
pipe_valid  out  1  datapath stage-0 valid; equal to issue
out_wr_en  out  1  write the highlight output FIFO; issue delayed by PIPE_LAT
out_rd_en  in  1  consumer pop of the highlight output FIFO; returns one credit
busy  out  1  high in RUN and DRAIN
frame_done  out  1  one-cycle pulse when the last word of the frame is written
credits  out  clog2(OUT_DEPTH+1)  free output slots not yet reserved (debug/verification)

Behaviour:
- Input FIFOs are show-ahead: dout is valid while !empty, and rd_en pops.
- issue = (state==RUN) & !bg_empty & !fr_empty & !hl_empty & (credits!=0) & (issued_cnt!=frame_len).
- bg_rd_en = fr_rd_en = hl_rd_en = pipe_valid = issue. Zero-cycle combinational path; no registered stage.
- out_wr_en = issue delayed through a PIPE_LAT-deep shift register. The register keeps running in every state and is cleared only by reset.
- Credits:
  - reset value = OUT_DEPTH;
  - next = credits - issue + out_rd_en;
  - issue and out_rd_en in the same cycle leave credits unchanged;
  - out_rd_en when credits==OUT_DEPTH is ignored (saturate); flag it with a simulation assertion.
  - Credits are not reset at start; they persist across frames.
- Counters:
  - issued_cnt and written_cnt are PIX_W wide and cleared on an accepted start.
  - issued_cnt increments on issue.
  - written_cnt increments on out_wr_en.
- States:
  - IDLE: start=1 latches frame_len=frame_pixels and clears counters. If frame_pixels==0, go to DONE; else go to RUN.
  - RUN: issue as permitted. On the cycle issue makes issued_cnt reach frame_len, go to DRAIN.
  - DRAIN: no issue. When out_wr_en makes written_cnt reach frame_len, go to DONE.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored; frame_pixels changes mid-frame have no effect.
- A start in the DONE cycle is ignored. Earliest next start is the cycle after frame_done.
- Frame latency:
  - first out_wr_en comes PIPE_LAT cycles after the first issue;
  - frame_done comes the cycle after the last out_wr_en.
  - With all FIFOs non-empty and credits available, throughput is 1 word/cycle.
- Empty on any one input FIFO stalls all three; no partial pops ever.
- Reset, including mid-frame:
  - state IDLE; counters 0; credits=OUT_DEPTH; delay line cleared;
  - all outputs 0 except credits.
  - Reset does not flush the external FIFOs; the top level resets them on the same reset.

Decomposition:
- Package motion_pkg:
  - state enum sched_state_t {S_IDLE, S_RUN, S_DRAIN, S_DONE};
  - constants PIX_W, PIPE_LAT, OUT_DEPTH, for sharing with motion_detect_top and the datapath.
- One natural sub-module: valid_delay_line (PIPE_LAT-deep 1-bit shift register with synchronous clear). Counters and FSM stay in the top.

Test Plan:
- Frame of 8 words, all FIFOs pre-filled, out_rd_en tied high, PIPE_LAT=4 -> issue on 8 consecutive cycles; out_wr_en on cycles 4..11 after the first issue; frame_done pulses once, cycle 12; busy falls with it.
- Same frame, hl_empty held high for cycles 2-4 of RUN -> bg/fr/hl rd_en all low during the stall (never split); exactly 8 pops total; frame_done still after 8 writes.
- OUT_DEPTH=32, frame_pixels=40, out_rd_en=0 -> exactly 32 issues, then stall with credits==0; release out_rd_en for 8 cycles -> remaining 8 issue; credits returns to 32 after the consumer drains all 40.
- frame_pixels=0 with start -> no rd_en or out_wr_en; frame_done pulses the cycle after start.
- start re-pulsed during RUN with frame_pixels=3 on a 10-word frame -> ignored; 10 pops; one frame_done.
- reset asserted mid-frame after 5 of 10 issues -> next cycle: state IDLE, all outputs 0, credits=OUT_DEPTH, no pending out_wr_en emerges; a new start runs a full frame correctly.
